// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and sizing helpers for the UART frame transmit arbiter.
package uart_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Header byte base; the grant id is OR-ed into the low 3 bits.
  localparam logic [7:0] FRAME_HDR_BASE = 8'hA0;

  // Byte index counts header(0), payload(1..NBYTES), checksum(NBYTES+1).
  function automatic int idx_width(input int nbytes);
    return $clog2(nbytes + 2);
  endfunction

  // Width needed to select one of nbytes payload bytes.
  function automatic int bsel_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  // Watchdog must reach timeout-1.
  function automatic int wdog_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_id,
  output logic            any
);

  logic [NREQ-1:0] req_rot;
  logic [2:0]      off;
  logic [3:0]      id_sum;

  // Rotate so that bit 0 is the requester at ptr (ptr is always < NREQ).
  always_comb begin
    req_rot = NREQ'({req, req} >> ptr);
  end

  // Lowest rotated position wins; scanning downward leaves the lowest set bit.
  always_comb begin
    any = 1'b0;
    off = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any = 1'b1;
        off = 3'(k);
      end
    end
  end

  // Undo the rotation to recover the absolute requester id.
  assign id_sum = {1'b0, ptr} + {1'b0, off};
  assign gnt_id = (id_sum >= 4'(NREQ)) ? 3'(id_sum - 4'(NREQ)) : id_sum[2:0];

  genvar i;
  generate
    for (i = 0; i < NREQ; i++) begin : g_gnt
      assign gnt[i] = any & (gnt_id == 3'(i));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NREQ frame producers. Round-robin grant,
// snapshot of the winner's buffer, then header / payload / checksum bytes, each
// handed over with a uart_send pulse and acknowledged by uart_send_done.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NREQ     = 2,
  parameter int         NBYTES   = 40,
  parameter logic [7:0] HDR_BASE = FRAME_HDR_BASE,
  parameter int         TIMEOUT  = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*NBYTES*8-1:0] req_data,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic                     uart_send,
  output logic [7:0]               send_data,
  input  logic                     uart_send_done
);

  localparam int FRAME_W = NBYTES * 8;
  localparam int IDX_W   = idx_width(NBYTES);
  localparam int BSEL_W  = bsel_width(NBYTES);
  localparam int WD_W    = wdog_width(TIMEOUT);

  localparam logic [IDX_W-1:0] PAY_END  = IDX_W'(NBYTES);
  localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NBYTES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic [NREQ-1:0][FRAME_W-1:0] req_frames;
  logic [FRAME_W-1:0]           sel_frame;
  logic [NBYTES-1:0][7:0]       buf_q;

  logic [NREQ-1:0]  arb_gnt, gnt_q;
  logic [2:0]       arb_id, rr_ptr, ptr_nxt;
  logic             arb_any;
  logic [3:0]       ptr_inc;

  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0]  wdog;
  logic [7:0]       csum, cur_byte, hdr_byte;
  logic             abort_q;
  logic             wd_expire;

  assign req_frames = req_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // One-hot AND-OR mux of the winning requester's buffer.
  always_comb begin
    sel_frame = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) sel_frame = sel_frame | req_frames[i];
    end
  end

  // Byte that goes out on the next ack: buffer byte idx while in payload, else checksum.
  assign cur_byte  = (idx < PAY_END) ? buf_q[idx[BSEL_W-1:0]] : csum;
  assign hdr_byte  = HDR_BASE | {5'd0, arb_id};
  assign wd_expire = (wdog == WD_LAST);
  assign ptr_inc   = {1'b0, grant_id} + 4'd1;
  assign ptr_nxt   = (ptr_inc >= 4'(NREQ)) ? 3'd0 : ptr_inc[2:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    state_nxt = state;
    uart_send = 1'b0;
    busy      = 1'b1;
    done      = '0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (arb_any) state_nxt = SEND;
      end
      SEND: begin
        uart_send = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (uart_send_done) state_nxt = (idx == CSUM_IDX) ? DONE : SEND;
        else if (wd_expire) state_nxt = DONE;
      end
      DONE: begin
        done      = gnt_q;
        err       = abort_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: grant snapshot, byte sequencing, checksum, watchdog, rr pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q     <= '0;
      gnt_q     <= '0;
      grant_id  <= 3'd0;
      rr_ptr    <= 3'd0;
      idx       <= '0;
      wdog      <= '0;
      csum      <= 8'd0;
      send_data <= 8'd0;
      abort_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            buf_q     <= sel_frame;
            gnt_q     <= arb_gnt;
            grant_id  <= arb_id;
            idx       <= '0;
            send_data <= hdr_byte;
            csum      <= hdr_byte;
            abort_q   <= 1'b0;
          end
        end
        SEND: begin
          // Any ack seen here belongs to nothing we are waiting for.
          wdog <= '0;
        end
        WAIT: begin
          if (uart_send_done) begin
            if (idx != CSUM_IDX) begin
              idx       <= idx + IDX_W'(1);
              send_data <= cur_byte;
              if (idx < PAY_END) csum <= csum + cur_byte;
            end
          end else begin
            wdog <= wdog + WD_W'(1);
            if (wd_expire) abort_q <= 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model that acks 10 cycles
// after each uart_send unless stalled.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 2;
  localparam int NBYTES  = 40;
  localparam int TIMEOUT = 100;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          req;
  logic [NREQ*NBYTES*8-1:0] req_data;
  logic [NREQ-1:0]          done;
  logic                     err, busy, uart_send, uart_send_done;
  logic [2:0]               grant_id;
  logic [7:0]               send_data;

  logic tx_done = 1'b0;
  logic inj_done, stall;
  int   tx_cnt = 0;
  int   cyc = 0;

  logic [7:0] sent_q[$];
  int         send_cyc_q[$];
  logic [2:0] dn_q[$];
  int         dn_cyc_q[$];

  int errors = 0;
  int checks = 0;

  assign uart_send_done = tx_done | inj_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ), .NBYTES(NBYTES), .HDR_BASE(8'hA0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .done(done), .err(err), .busy(busy), .grant_id(grant_id),
    .uart_send(uart_send), .send_data(send_data), .uart_send_done(uart_send_done)
  );

  // Transmitter model and log of sent bytes / done pulses, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (uart_send === 1'b1) begin
        sent_q.push_back(send_data);
        send_cyc_q.push_back(cyc);
        if (!stall) tx_cnt = 10;
      end
      if (done !== '0 || err !== 1'b0) begin
        dn_q.push_back({err, done});
        dn_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sent_at(input int i);
    if (i >= 0 && i < sent_q.size()) return sent_q[i];
    return 8'hxx;
  endfunction

  function automatic logic [2:0] dn_at(input int i);
    if (i >= 0 && i < dn_q.size()) return dn_q[i];
    return 3'bxxx;
  endfunction

  function automatic int cyc_diff(input int di, input int si);
    if (di < dn_cyc_q.size() && si < send_cyc_q.size()) return dn_cyc_q[di] - send_cyc_q[si];
    return -1;
  endfunction

  task automatic set_buf(input int id, input logic [7:0] v0);
    for (int b = 0; b < NBYTES; b++) req_data[(id * NBYTES + b) * 8 +: 8] = v0 + 8'(b);
  endtask

  // Steps at least once, then until a done pulse is visible (bounded).
  task automatic wait_done(input string tag, output logic [NREQ-1:0] d, output logic e);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (done === '0 && n < 800);
    chk({tag, "_done_seen"}, 32'(done !== '0), 32'd1);
    d = done;
    e = err;
  endtask

  task automatic wait_sent(input string tag, input int target);
    int n;
    n = 0;
    while (sent_q.size() < target && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_sent_reached"}, 32'(sent_q.size() >= target), 32'd1);
  endtask

  // Checks a full 42-byte frame starting at log index fs.
  task automatic chk_frame(input string tag, input int fs, input logic [7:0] hdr,
                           input logic [7:0] v0, input logic [7:0] sum);
    logic [7:0] exp;
    chk({tag, "_nsend"}, 32'(sent_q.size() - fs), 32'd42);
    for (int k = 0; k < 42; k++) begin
      if (k == 0)       exp = hdr;
      else if (k <= 40) exp = v0 + 8'(k - 1);
      else              exp = sum;
      chk($sformatf("%s_byte%0d", tag, k), 32'(sent_at(fs + k)), 32'(exp));
    end
  endtask

  initial begin
    logic [NREQ-1:0] d;
    logic            e;
    int              fs, nd;

    rst = 1'b0; req = '0; req_data = '0; inj_done = 1'b0; stall = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_send", 32'(uart_send), 32'd0);
    chk("rst_data", 32'(send_data), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    rst = 1'b1;
    repeat (2) step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single frame from requester 0, bytes 01..28
    set_buf(0, 8'h01);
    set_buf(1, 8'h01);
    fs = sent_q.size(); nd = dn_q.size();
    req = 2'b01;
    step();
    chk("t2_latency_send", 32'(uart_send), 32'd1);
    chk("t2_hdr", 32'(send_data), 32'hA0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_gid", 32'(grant_id), 32'd0);
    wait_done("t2", d, e);
    req = '0;
    chk("t2_done", 32'(d), 32'b01);
    chk("t2_err", 32'(e), 32'd0);
    chk("t2_busy_in_done", 32'(busy), 32'd1);
    chk_frame("t2", fs, 8'hA0, 8'h01, 8'hD4);
    step();
    chk("t2_busy_fall", 32'(busy), 32'd0);
    chk("t2_done_fall", 32'(done), 32'd0);
    repeat (20) step();
    chk("t2_one_done", 32'(dn_q.size() - nd), 32'd1);

    // Reset in the middle of a requester-1 frame
    req = 2'b10;
    fs = sent_q.size();
    wait_sent("t1", fs + 6);
    chk("t1_gid_before", 32'(grant_id), 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_send", 32'(uart_send), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_data", 32'(send_data), 32'd0);
    chk("t1_gid", 32'(grant_id), 32'd0);
    req = '0;
    nd = dn_q.size(); fs = sent_q.size();
    repeat (3) step();
    rst = 1'b1;
    repeat (30) step();
    chk("t1_no_send", 32'(sent_q.size() - fs), 32'd0);
    chk("t1_no_done", 32'(dn_q.size() - nd), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Both requesting from reset: strict alternation 0,1,0,1
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      fs = sent_q.size();
      wait_done($sformatf("t3_f%0d", f), d, e);
      chk($sformatf("t3_done_f%0d", f), 32'(d), (f % 2 == 0) ? 32'b01 : 32'b10);
      chk($sformatf("t3_hdr_f%0d", f), 32'(sent_at(fs)), (f % 2 == 0) ? 32'hA0 : 32'hA1);
      if (f == 1) chk("t3_csum_id1", 32'(sent_at(fs + 41)), 32'hD5);
    end
    req = '0;
    step();

    // Snapshot: change data and drop req mid-frame
    set_buf(1, 8'h10);
    fs = sent_q.size();
    req = 2'b10;
    wait_sent("t4", fs + 5);
    set_buf(1, 8'h80);
    req = '0;
    wait_done("t4", d, e);
    chk("t4_done", 32'(d), 32'b10);
    chk("t4_err", 32'(e), 32'd0);
    chk_frame("t4", fs, 8'hA1, 8'h10, 8'h2D);
    step();

    // Transmitter stalls after header: watchdog abort
    stall = 1'b1;
    fs = sent_q.size(); nd = dn_q.size();
    req = 2'b01;
    wait_done("t5", d, e);
    req = '0;
    chk("t5_done", 32'(d), 32'b01);
    chk("t5_err", 32'(e), 32'd1);
    step();
    chk("t5_busy_fall", 32'(busy), 32'd0);
    chk("t5_err_fall", 32'(err), 32'd0);
    chk("t5_log", 32'(dn_at(nd)), 32'b101);
    chk("t5_timing", 32'(cyc_diff(nd, fs)), 32'd101);
    chk("t5_nsend", 32'(sent_q.size() - fs), 32'd1);

    // Ack during SEND is ignored; only an ack in WAIT advances
    fs = sent_q.size();
    req = 2'b01;
    step();
    chk("t6_send", 32'(uart_send), 32'd1);
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    repeat (5) step();
    chk("t6_ignored", 32'(sent_q.size() - fs), 32'd1);
    chk("t6_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    chk("t6_next_send", 32'(uart_send), 32'd1);
    chk("t6_byte0", 32'(send_data), 32'h01);
    wait_done("t6", d, e);
    req = '0;
    chk("t6_done", 32'(d), 32'b01);
    chk("t6_err", 32'(e), 32'd0);
    chk_frame("t6", fs, 8'hA0, 8'h01, 8'hD4);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
